// File: rtl/fir_tap_sequencer_pkg.sv
// Shared types and constants for the FIR tap sequencer.
package fir_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DRAIN, ST_DONE} state_e;

  localparam logic [1:0] ALU_OP_ADD = 2'b00;
  localparam logic [1:0] ALU_OP_MUL = 2'b01;

  localparam int SMP_W  = 16;
  localparam int COEF_W = 16;
  localparam int ACC_W  = 32;
endpackage

// File: rtl/fir_tap_sequencer_if.sv
// Sample/coef/ALU/result bundle for fir_tap_sequencer.
// FIR_TAP_SEQUENCER_SAT_EN adds the sticky sat_flag output.
interface fir_tap_sequencer_if
  import fir_pkg::*;
#(parameter int NTAPS = 64) ();
  localparam int AW = $clog2(NTAPS);

  logic [SMP_W-1:0]  x_data;
  logic              x_valid;
  logic              x_ready;
  logic              coef_we;
  logic [AW-1:0]     coef_addr;
  logic [COEF_W-1:0] coef_data;
  logic [SMP_W-1:0]  alu_a;
  logic [COEF_W-1:0] alu_b;
  logic [1:0]        alu_op;
  logic [ACC_W-1:0]  alu_result;
  logic [ACC_W-1:0]  y_data;
  logic              y_valid;
  logic              y_ready;
  logic              busy;
`ifdef FIR_TAP_SEQUENCER_SAT_EN
  logic              sat_flag;

  modport slave (
    input  x_data, x_valid, coef_we, coef_addr, coef_data, alu_result, y_ready,
    output x_ready, alu_a, alu_b, alu_op, y_data, y_valid, busy, sat_flag
  );
  modport master (
    output x_data, x_valid, coef_we, coef_addr, coef_data, alu_result, y_ready,
    input  x_ready, alu_a, alu_b, alu_op, y_data, y_valid, busy, sat_flag
  );
`else
  modport slave (
    input  x_data, x_valid, coef_we, coef_addr, coef_data, alu_result, y_ready,
    output x_ready, alu_a, alu_b, alu_op, y_data, y_valid, busy
  );
  modport master (
    output x_data, x_valid, coef_we, coef_addr, coef_data, alu_result, y_ready,
    input  x_ready, alu_a, alu_b, alu_op, y_data, y_valid, busy
  );
`endif
endinterface

// File: rtl/fir_tap_sequencer_delay_line.sv
// Circular sample store: write at wr_ptr, read at (wr_ptr - offset) mod NTAPS.
module fir_delay_line
  import fir_pkg::*;
#(
  parameter int NTAPS = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [SMP_W-1:0]         wr_data_i,
  input  logic                     adv_i,
  input  logic [$clog2(NTAPS)-1:0] rd_off_i,
  output logic [SMP_W-1:0]         rd_data_o
);
  localparam int AW = $clog2(NTAPS);

  logic [SMP_W-1:0] mem_q [NTAPS];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_idx;

  // NTAPS is a power of two, so pointer arithmetic wraps for free.
  assign rd_idx    = wr_ptr_q - rd_off_i;
  assign rd_data_o = mem_q[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      for (int i = 0; i < NTAPS; i++) mem_q[i] <= '0;
    end else begin
      if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
      if (adv_i)   wr_ptr_q <= wr_ptr_q + AW'(1);
    end
  end
endmodule

// File: rtl/fir_tap_sequencer.sv
// Direct-form FIR sequencer driving a shared multiply/add ALU one tap per cycle.
// FIR_TAP_SEQUENCER_SAT_EN selects saturating accumulate plus sat_flag.
module fir_tap_sequencer
  import fir_pkg::*;
#(
  parameter int NTAPS   = 64,
  parameter int ALU_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  fir_tap_sequencer_if.slave   bus
);
  localparam int            AW       = $clog2(NTAPS);
  localparam logic [AW-1:0] LAST_TAP = AW'(NTAPS - 1);

  state_e            state_q, state_d;
  logic              rst_q;
  logic [AW-1:0]     tap_q, tap_d, tap_nxt;
  logic [ALU_LAT:0]  vld_pipe;
  logic              issue_d;
  logic [SMP_W-1:0]  alu_a_q, alu_a_d, dl_rd;
  logic [COEF_W-1:0] alu_b_q, alu_b_d;
  logic [1:0]        alu_op_q, alu_op_d;
  logic [ACC_W-1:0]  acc_q, acc_sum;
  logic [COEF_W-1:0] coef_q [NTAPS];
  logic              accept, coef_wr, y_fire, drained;

  assign bus.x_ready = (state_q == ST_IDLE) && !rst_q;
  assign bus.y_valid = (state_q == ST_DONE);
  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.y_data  = acc_q;
  assign bus.alu_a   = alu_a_q;
  assign bus.alu_b   = alu_b_q;
  assign bus.alu_op  = alu_op_q;

  assign accept  = bus.x_valid && bus.x_ready;
  assign coef_wr = bus.coef_we && (state_q == ST_IDLE);
  assign y_fire  = bus.y_valid && bus.y_ready;
  assign tap_nxt = tap_q + AW'(1);
  // Only the final stage may still be live: it lands this cycle.
  assign drained = (vld_pipe[ALU_LAT-1:0] == '0);

  fir_delay_line #(.NTAPS(NTAPS)) u_dline (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (accept),
    .wr_data_i (bus.x_data),
    .adv_i     (y_fire),
    .rd_off_i  (tap_nxt),
    .rd_data_o (dl_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    tap_d    = tap_q;
    issue_d  = 1'b0;
    alu_a_d  = '0;
    alu_b_d  = '0;
    alu_op_d = ALU_OP_ADD;
    case (state_q)
      ST_IDLE: if (accept) begin
        // Tap 0 bypasses both stores: the sample and a same-cycle coef[0] write land this edge.
        state_d  = ST_MUL;
        tap_d    = '0;
        issue_d  = 1'b1;
        alu_a_d  = bus.x_data;
        alu_b_d  = (coef_wr && bus.coef_addr == '0) ? bus.coef_data : coef_q[0];
        alu_op_d = ALU_OP_MUL;
      end
      ST_MUL: if (tap_q == LAST_TAP) begin
        state_d = ST_DRAIN;
      end else begin
        tap_d    = tap_nxt;
        issue_d  = 1'b1;
        alu_a_d  = dl_rd;
        alu_b_d  = coef_q[tap_nxt];
        alu_op_d = ALU_OP_MUL;
      end
      ST_DRAIN: if (drained) state_d = ST_DONE;
      ST_DONE:  if (bus.y_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

`ifdef FIR_TAP_SEQUENCER_SAT_EN
  logic [ACC_W:0] sum_w;
  logic           ovf, sat_q;

  assign sum_w   = {acc_q[ACC_W-1], acc_q} + {bus.alu_result[ACC_W-1], bus.alu_result};
  assign ovf     = sum_w[ACC_W] ^ sum_w[ACC_W-1];
  assign acc_sum = ovf ? (sum_w[ACC_W] ? 32'h8000_0000 : 32'h7fff_ffff) : sum_w[ACC_W-1:0];
  assign bus.sat_flag = sat_q;

  always_ff @(posedge clk) begin
    if (rst)                          sat_q <= 1'b0;
    else if (accept)                  sat_q <= 1'b0;
    else if (vld_pipe[ALU_LAT] && ovf) sat_q <= 1'b1;
  end
`else
  assign acc_sum = acc_q + bus.alu_result;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rst_q    <= 1'b1;
      tap_q    <= '0;
      vld_pipe <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= ALU_OP_ADD;
      acc_q    <= '0;
      for (int i = 0; i < NTAPS; i++) coef_q[i] <= '0;
    end else begin
      rst_q    <= 1'b0;
      tap_q    <= tap_d;
      vld_pipe <= {vld_pipe[ALU_LAT-1:0], issue_d};
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      if (coef_wr) coef_q[bus.coef_addr] <= bus.coef_data;
      if (accept)                 acc_q <= '0;
      else if (vld_pipe[ALU_LAT]) acc_q <= acc_sum;
    end
  end
endmodule

// File: doc/fir_tap_sequencer.md
# fir_tap_sequencer

Sequencer that turns the shared 16x16 multiply/add ALU into a direct-form FIR filter. It holds the coefficient bank and sample delay line, accepts one input sample per handshake, and issues one multiply per tap to the ALU. It accumulates the returned products into a 32-bit result presented on a valid/ready output. It sits between the sample source and the output sink, directly in front of the `alu` instance.

## Interface
Parameters:
- `NTAPS`, 64: number of taps; power of two, at least 2.
- `ALU_LAT`, 1: cycles from operands and op presented to `alu_result` valid.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `x_data`  in  16  signed input sample.
- `x_valid`  in  1  `x_data` valid.
- `x_ready`  out  1  sample accepted when `x_valid && x_ready`.
- `coef_we`  in  1  coefficient write strobe.
- `coef_addr`  in  `$clog2(NTAPS)`  tap index.
- `coef_data`  in  16  signed coefficient.
- `alu_a`  out  16  ALU operand a; carries the sample.
- `alu_b`  out  16  ALU operand b; carries the coefficient.
- `alu_op`  out  2  ALU op select: 2'b00 add, 2'b01 multiply.
- `alu_result`  in  32  ALU result.
- `y_data`  out  32  signed filter output.
- `y_valid`  out  1  `y_data` valid.
- `y_ready`  in  1  sink accepts when `y_valid && y_ready`.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, MUL, DRAIN, DONE.
- IDLE:
  - `x_ready`=1.
  - On an accepted sample, write it to `dline[wr_ptr]`, clear `acc` and `tap`, and go to MUL.
- MUL, one tap per cycle:
  - `alu_a`=`dline[(wr_ptr - tap) mod NTAPS]` (newest sample first).
  - `alu_b`=`coef[tap]`.
  - `alu_op`=2'b01.
  - When `tap`==NTAPS-1, go to DRAIN.
- Issue tracking: an ALU_LAT-deep valid shift register follows every issued multiply. When a valid emerges, `acc <= acc + alu_result`.
- DRAIN: waits ALU_LAT cycles until the last product is accumulated, then goes to DONE.
- DONE:
  - `y_valid`=1 and `y_data`=`acc`.
  - On `y_ready`: advance `wr_ptr` (wraps NTAPS-1 to 0) and go to IDLE.
  - `y_data` is held stable while stalled.
- Outside MUL, the ALU is driven with `alu_op`=2'b00 and `alu_a`=`alu_b`=0.
- Coefficient writes:
  - Accepted only in IDLE.
  - Writes in any other state are ignored; the bank never changes mid-convolution.
  - A write and a sample accept in the same IDLE cycle are both taken; the new coefficient applies to this sample.
- Arithmetic:
  - Products are signed 32-bit from the ALU.
  - Accumulation is two's-complement and wraps modulo 2^32 (unless the saturation feature below is enabled).
- Reset:
  - Clears `dline`, `coef`, `acc`, `tap`, `wr_ptr`, and the issue pipeline; state returns to IDLE.
  - Asserting `rst` mid-operation aborts the operation; the sample and partial sum are discarded.
  - Output values during reset: `x_ready`=0, `y_valid`=0, `y_data`=0, `busy`=0, `alu_op`=2'b00, `alu_a`=0, `alu_b`=0.
  - `x_ready` goes to 1 in the first cycle after `rst` deasserts.

## Timing
- Sample accepted at edge 0. MUL occupies cycles 1..NTAPS. DRAIN occupies the next ALU_LAT cycles.
- `y_valid` rises in cycle NTAPS+ALU_LAT+1 after the accept.
- Throughput: at most one sample per NTAPS+ALU_LAT+2 cycles with `y_ready` tied high.
- `x_ready`, `y_valid`, and `busy` are decoded directly from registered state; there is no combinational path from `x_valid` or `y_ready`.
- All ALU-facing outputs are registered.

## Configuration
- `FIR_TAP_SEQUENCER_SAT_EN` defined: each accumulate saturates to [-2^31, 2^31-1] on signed overflow, and a sticky `sat_flag` out (1 bit) is added. `sat_flag` is cleared when the sample is accepted and is visible with `y_valid`.
- `FIR_TAP_SEQUENCER_SAT_EN` undefined: wrapping accumulate, and no `sat_flag` port.

## Structure
- Package `fir_pkg`:
  - state enum.
  - ALU op constants `ALU_OP_ADD`=2'b00 and `ALU_OP_MUL`=2'b01.
  - sample, coefficient, and accumulator width constants (16/16/32).
- Sub-module `fir_delay_line`: NTAPS x 16 register array with write pointer, wrap logic, and a tap-offset read port.
- Control FSM, coefficient bank, and accumulator stay in the top module.

## Test plan
- Impulse response:
  - Stimulus: NTAPS=64, ALU_LAT=1, coef[k]=k+1; feed x=1, then 63 zeros.
  - Required: outputs 1, 2, …, 64, and each `y_valid` at cycle 66 after its accept.
- Known convolution: coef all 2; feed x=3,5 → y=6, then 16.
- Backpressure: hold `y_ready`=0 for 10 cycles in DONE → `y_data` stable, `x_ready`=0, `busy`=1; the next sample is accepted only after the handshake.
- Coefficient write while `busy`: write coef[0]=100 in MUL → ignored, output unchanged versus the reference model; the same write in IDLE takes effect.
- Reset mid-MUL: assert `rst` at tap 20 → the cycle after, `y_valid`=0, `busy`=0, `alu_op`=00; the next impulse yields all zeros until coefficients are reloaded.
- Overflow: coef all 32767, x=32767 repeated 64 times → wraps without `FIR_TAP_SEQUENCER_SAT_EN`; with it, saturates to 2147483647 and `sat_flag`=1.
